// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with optional first-word-fall-through
// read path, programmable almost-full/almost-empty levels and occupancy count.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter bit FWFT       = 1'b0,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic [CNT_W-1:0]      af_thresh,
  input  logic [CNT_W-1:0]      ae_thresh,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CNT_W-1:0]      count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  assign full        = (count == FULL_CNT);
  assign empty       = (count == '0);
  assign almostfull  = (count >= af_thresh);
  assign almostempty = (count <= ae_thresh);
  assign wr_acc      = wr_en & ~full;
  assign rd_acc      = rd_en & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // explicit wrap keeps non-power-of-2 depths correct
      if (wr_acc)
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      if (rd_acc)
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      wr_ack    <= wr_acc;
      overflow  <= wr_en & full;
      underflow <= rd_en & empty;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_acc)
      mem[wr_ptr] <= data_in;
  end

  generate
    if (FWFT) begin : g_fwft
      assign data_out = mem[rd_ptr];
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] rd_q;
      always_ff @(posedge clk) begin
        if (rst)
          rd_q <= '0;
        else if (rd_acc)
          rd_q <= mem[rd_ptr];
      end
      assign data_out = rd_q;
    end
  endgenerate

endmodule
